serial_word_deserializer: RTL

//  Receive end of the filter-output serial link. Rebuilds WIDTH-bit words from the

---
 rtl/deser_pkg.sv | 19 +
 rtl/strobe_edge_detect.sv | 50 +++++
 rtl/serial_word_deserializer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/deser_pkg.sv
// ============================================================================
// Module : deser_pkg
// Brief  : Shared types and defaults for the serial word deserializer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package deser_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int DESER_DEFAULT_WIDTH = 12;

endpackage : deser_pkg

`default_nettype wire

// File: rtl/strobe_edge_detect.sv
// ============================================================================
// Module : strobe_edge_detect
// Brief  : Optional 2-flop synchronizer (STROBE_SYNC_EN) + rising-edge detect.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module strobe_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q_sync,
  output logic rise
);

`ifdef STROBE_SYNC_EN
  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q_sync = r_sync;
`else
  assign q_sync = d;
`endif

  // History clears on reset, so a strobe held high through reset reads as a new edge.
  logic r_hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= 1'b0;
    end else begin
      r_hist <= q_sync;
    end
  end

  assign rise = q_sync & ~r_hist;

endmodule : strobe_edge_detect

`default_nettype wire

// File: rtl/serial_word_deserializer.sv
// ============================================================================
// Module : serial_word_deserializer
// Brief  : Rebuilds WIDTH-bit MSB-first words from strobed serial input and
//          presents them over valid/ready. Input sync enabled by STROBE_SYNC_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_word_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH = DESER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_data,
  input  logic             shift,
  input  logic             serial_data_in,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun,
  output logic             frame_err
);

  localparam int               CNT_W      = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);

  logic w_ld_rise;
  logic w_sh_rise;
  logic w_sd;
  logic w_ld_sync_unused;
  logic w_sh_sync_unused;
  logic w_sd_rise_unused;

  strobe_edge_detect u_ld_edge (
    .clk    (clk),
    .rst    (rst),
    .d      (load_data),
    .q_sync (w_ld_sync_unused),
    .rise   (w_ld_rise)
  );

  strobe_edge_detect u_sh_edge (
    .clk    (clk),
    .rst    (rst),
    .d      (shift),
    .q_sync (w_sh_sync_unused),
    .rise   (w_sh_rise)
  );

  strobe_edge_detect u_sd_sync (
    .clk    (clk),
    .rst    (rst),
    .d      (serial_data_in),
    .q_sync (w_sd),
    .rise   (w_sd_rise_unused)
  );

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_sreg_nxt;
  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_overrun;
  logic             r_ferr;
  logic             w_ferr_nxt;
  logic             w_done;
  logic             w_read;
  logic             w_out_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sreg  <= '0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sreg  <= w_sreg_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  // Load takes priority over a coincident shift edge; that bit is not sampled.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sreg_nxt  = r_sreg;
    w_ferr_nxt  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ld_rise) begin
          w_state_nxt = RECV;
          w_cnt_nxt   = '0;
          w_sreg_nxt  = '0;
        end
      end
      RECV: begin
        if (w_ld_rise) begin
          w_ferr_nxt = (r_cnt != '0);
          w_cnt_nxt  = '0;
          w_sreg_nxt = '0;
        end else if (w_sh_rise) begin
          w_sreg_nxt = {r_sreg[WIDTH-2:0], w_sd};
          w_cnt_nxt  = r_cnt + 1'b1;
          if (r_cnt == c_last_bit) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_read     = r_valid & word_ready;
  assign w_out_free = ~r_valid | word_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_done && w_out_free) begin
        r_word  <= w_sreg_nxt;
        r_valid <= 1'b1;
      end else begin
        if (w_done) begin
          r_overrun <= 1'b1;
        end
        if (w_read) begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign word_out   = r_word;
  assign word_valid = r_valid;
  assign overrun    = r_overrun;
  assign frame_err  = r_ferr;

endmodule : serial_word_deserializer

`default_nettype wire
